// File: rtl/gpio_popcount_stage.sv
// Serial popcount stage for the GPIO emulator multiply datapath: counts set bits of each
// product word BITS_PER_CYC at a time. Define POPCOUNT_PARITY_EN to drive out_parity.
module gpio_popcount_stage #(
  parameter int DATA_W       = 49,
  parameter int BITS_PER_CYC = 4,
  parameter int CNT_W        = 24
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [6:0]        out_ones,
  output logic              out_ovf,
  output logic              out_parity,
  output logic              busy,
  input  logic              clr,
  output logic [CNT_W-1:0]  total_ones,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int N      = (DATA_W + BITS_PER_CYC - 1) / BITS_PER_CYC;
  localparam int CYC_W  = (N > 1) ? $clog2(N) : 1;
  localparam int ONES_W = ($clog2(DATA_W + 1) > 7) ? $clog2(DATA_W + 1) : 7;
  // Padded to whole slices so the final slice sees zero fill above DATA_W.
  localparam int SREG_W = N * BITS_PER_CYC;
  localparam int SUM_W  = ((CNT_W > ONES_W) ? CNT_W : ONES_W) + 1;
  localparam logic [SUM_W-1:0] SUM_MAX = SUM_W'({CNT_W{1'b1}});
  localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(N - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_e;

  state_e              state_q;
  logic [SREG_W-1:0]   sreg_q;
  logic [CYC_W-1:0]    cyc_q;
  logic [ONES_W-1:0]   ones_q;
  logic                ovf_q;
  logic                valid_q;
  logic [CNT_W-1:0]    total_q;
  logic [CNT_W-1:0]    word_q;
  logic [CNT_W-1:0]    total_d;
  logic [SUM_W-1:0]    sum;
  logic                handshake;

  function automatic logic [ONES_W-1:0] slice_ones(input logic [BITS_PER_CYC-1:0] s);
    logic [ONES_W-1:0] c;
    c = '0;
    for (int i = 0; i < BITS_PER_CYC; i++) c = c + ONES_W'(s[i]);
    return c;
  endfunction

  assign handshake = (state_q == DONE) && out_ready;

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    sum     = SUM_W'(total_q) + SUM_W'(ones_q);
    total_d = total_q;
    if (sum > SUM_MAX) total_d = '1;
    else               total_d = sum[CNT_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cyc_q   <= '0;
      ones_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      total_q <= '0;
      word_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sreg_q  <= SREG_W'(in_data);
          ovf_q   <= in_ovf;
          ones_q  <= '0;
          cyc_q   <= '0;
          state_q <= COUNT;
        end
        COUNT: begin
          ones_q <= ones_q + slice_ones(sreg_q[BITS_PER_CYC-1:0]);
          sreg_q <= sreg_q >> BITS_PER_CYC;
          cyc_q  <= cyc_q + CYC_W'(1);
          if (cyc_q == LAST_CYC) begin
            state_q <= DONE;
            valid_q <= 1'b1;
          end
        end
        DONE: if (out_ready) begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // A clear outranks the completing word; the word is then simply not counted.
      if (clr) begin
        total_q <= '0;
        word_q  <= '0;
      end else if (handshake) begin
        total_q <= total_d;
        word_q  <= word_q + CNT_W'(1);
      end
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign out_valid  = valid_q;
  assign out_ones   = ones_q[6:0];
  assign out_ovf    = ovf_q;
  assign total_ones = total_q;
  assign word_cnt   = word_q;

`ifdef POPCOUNT_PARITY_EN
  assign out_parity = valid_q & ones_q[0];
`else
  assign out_parity = 1'b0;
`endif

endmodule
